// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer and the decode units:
// RV32 opcode constants, sequencer state encoding, next-PC bundle, helpers.
package pc_sequencer_pkg;

    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_TRAP
    } state_t;

    // Result of the EXEC-stage next-PC evaluation.
    typedef struct packed {
        logic [31:0] next_pc;
        logic        illegal;
        logic        misaligned;
        logic        writes_rd;
    } next_sel_t;

    function automatic logic opcode_legal(input logic [6:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_LUI,
            OP_AUIPC, OP_BRANCH, OP_JAL, OP_JALR: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Opcodes that produce a register-file result (stores and branches do not).
    function automatic logic opcode_writes(input logic [6:0] op);
        logic wr;
        wr = 1'b0;
        case (op)
            OP_OP, OP_IMM, OP_LOAD, OP_LUI,
            OP_AUIPC, OP_JAL, OP_JALR: wr = 1'b1;
            default: wr = 1'b0;
        endcase
        return wr;
    endfunction

    // Retired-instruction counter step; wraps modulo 2^32.
    function automatic logic [31:0] retired_inc(input logic [31:0] cnt);
        return cnt + 32'd1;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection and legality check for the EXEC stage.
// Ports: opcode/rd fields of IR, current PC, datapath target, branch outcome -> next_sel_t.
module pc_next_sel
    import pc_sequencer_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [31:0] pc,
    input  logic [31:0] pcbr,
    input  logic        br_taken,
    output next_sel_t   sel
);

    logic [31:0] pc_inc;
    logic [31:0] target;

    always_comb begin
        pc_inc = pc + PC_STEP;
        target = pc_inc;
        unique case (1'b1)
            (opcode == OP_JAL),
            (opcode == OP_JALR):   target = pcbr;
            (opcode == OP_BRANCH): target = br_taken ? pcbr : pc_inc;
            default:               target = pc_inc;
        endcase
    end

    always_comb begin
        sel            = '0;
        sel.next_pc    = target;
        sel.illegal    = !opcode_legal(opcode);
        sel.misaligned = (target[1:0] != 2'b00);
        sel.writes_rd  = opcode_writes(opcode) && (rd != 5'd0);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/exec/writeback sequencer with sticky trap.
// Ports: iCLK/iRST, IMEM req/addr/ack/data, oIR/oPC, iPCBR/iBR_TAKEN, oRF_WE, oTRAP, oRETIRED.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        iCLK,
    input  logic        iRST,
    output logic        oIMEM_REQ,
    output logic [31:0] oIMEM_ADDR,
    input  logic        iIMEM_ACK,
    input  logic [31:0] iIMEM_DATA,
    output logic [31:0] oIR,
    output logic [31:0] oPC,
    input  logic [31:0] iPCBR,
    input  logic        iBR_TAKEN,
    output logic        oRF_WE,
    output logic        oTRAP,
    output logic [31:0] oRETIRED
);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] npc_q;
    logic [31:0] retired_q;
    logic        req_q;
    logic        rf_we_q;
    logic        trap_q;
    next_sel_t   sel;

    pc_next_sel u_next_sel (
        .opcode   (ir_q[6:0]),
        .rd       (ir_q[11:7]),
        .pc       (pc_q),
        .pcbr     (iPCBR),
        .br_taken (iBR_TAKEN),
        .sel      (sel)
    );

    // PC only changes in WB, so the fetch address is stable across a wait.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            npc_q     <= RESET_PC;
            retired_q <= '0;
            req_q     <= 1'b0;
            rf_we_q   <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    req_q <= 1'b1;
                    if (iIMEM_ACK) begin
                        ir_q    <= iIMEM_DATA;
                        req_q   <= 1'b0;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    npc_q <= sel.next_pc;
                    if (sel.illegal || sel.misaligned) begin
                        state_q <= ST_TRAP;
                        trap_q  <= 1'b1;
                    end else begin
                        state_q <= ST_WB;
                        rf_we_q <= sel.writes_rd;
                    end
                end
                ST_WB: begin
                    rf_we_q   <= 1'b0;
                    pc_q      <= npc_q;
                    retired_q <= retired_inc(retired_q);
                    req_q     <= 1'b1;
                    state_q   <= ST_FETCH;
                end
                ST_TRAP: begin
                    req_q   <= 1'b0;
                    rf_we_q <= 1'b0;
                    trap_q  <= 1'b1;
                end
                default: begin
                    // Unreachable encodings park in the trap state.
                    state_q <= ST_TRAP;
                    req_q   <= 1'b0;
                    rf_we_q <= 1'b0;
                    trap_q  <= 1'b1;
                end
            endcase
        end
    end

    assign oIMEM_REQ  = req_q;
    assign oIMEM_ADDR = pc_q;
    assign oPC        = pc_q;
    assign oIR        = ir_q;
    assign oRF_WE     = rf_we_q;
    assign oTRAP      = trap_q;
    assign oRETIRED   = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a cycle-level reference model.
// Model is compared on every negedge; directed literals pin key points.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        ack = 1'b0;
    logic [31:0] data = '0;
    logic [31:0] pcbr = '0;
    logic        taken = 1'b0;
    logic        oIMEM_REQ;
    logic [31:0] oIMEM_ADDR;
    logic [31:0] oIR;
    logic [31:0] oPC;
    logic        oRF_WE;
    logic        oTRAP;
    logic [31:0] oRETIRED;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on = 1'b0;

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .oIMEM_REQ  (oIMEM_REQ),
        .oIMEM_ADDR (oIMEM_ADDR),
        .iIMEM_ACK  (ack),
        .iIMEM_DATA (data),
        .oIR        (oIR),
        .oPC        (oPC),
        .iPCBR      (pcbr),
        .iBR_TAKEN  (taken),
        .oRF_WE     (oRF_WE),
        .oTRAP      (oTRAP),
        .oRETIRED   (oRETIRED)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase counts cycles since the ACK (0 = waiting to fetch).
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_ir = '0;
    logic [31:0] m_ret = '0;
    logic [31:0] m_npc = RST_PC;
    bit          m_trap = 1'b0;
    bit          m_rst_last = 1'b1;
    int          m_phase = 0;

    function automatic bit m_legal(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h37,
                          7'h17, 7'h63, 7'h6F, 7'h67};
    endfunction

    function automatic bit m_writes(input logic [31:0] ir);
        return (ir[6:0] inside {7'h33, 7'h13, 7'h03, 7'h37,
                                7'h17, 7'h6F, 7'h67}) && (ir[11:7] != 0);
    endfunction

    always @(posedge iCLK) begin
        logic [6:0] op;
        logic [31:0] tgt;
        if (iRST) begin
            m_pc = RST_PC; m_ir = '0; m_ret = '0;
            m_trap = 1'b0; m_phase = 0; m_rst_last = 1'b1;
        end else begin
            m_rst_last = 1'b0;
            if (!m_trap) begin
                if (m_phase == 0) begin
                    if (ack) begin m_ir = data; m_phase = 1; end
                end else if (m_phase == 1) begin
                    m_phase = 2;
                end else if (m_phase == 2) begin
                    op = m_ir[6:0];
                    if (op == 7'h6F || op == 7'h67 || (op == 7'h63 && taken))
                        tgt = pcbr;
                    else
                        tgt = m_pc + 4;
                    m_npc = tgt;
                    if (!m_legal(op) || (tgt % 4) != 0) m_trap = 1'b1;
                    else m_phase = 3;
                end else begin
                    m_pc = m_npc;
                    m_ret = m_ret + 1;
                    m_phase = 0;
                end
            end
        end
    end

    always @(negedge iCLK) begin
        if (chk_on) begin
            check("m_req", oIMEM_REQ,
                  (!m_rst_last && !m_trap && m_phase == 0) ? 32'd1 : 32'd0);
            check("m_addr", oIMEM_ADDR, m_pc);
            check("m_pc", oPC, m_pc);
            check("m_ir", oIR, m_ir);
            check("m_rf_we", oRF_WE,
                  (!m_trap && m_phase == 3 && m_writes(m_ir)) ? 32'd1 : 32'd0);
            check("m_trap", oTRAP, m_trap ? 32'd1 : 32'd0);
            check("m_retired", oRETIRED, m_ret);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #2;
        end
    endtask

    // Waits (bounded) for a request, optionally stalls, then acks for one cycle.
    task automatic fetch(input logic [31:0] instr, input int delay);
        int t;
        logic [31:0] a0;
        t = 0;
        while (!oIMEM_REQ && t < 20) begin
            step(1);
            t++;
        end
        if (!oIMEM_REQ) begin
            n_checks++;
            n_errors++;
            $display("FAIL fetch_timeout: got req=0 expected req=1 at %0t", $time);
            return;
        end
        a0 = oIMEM_ADDR;
        for (int i = 0; i < delay; i++) begin
            step(1);
            check("addr_stable", oIMEM_ADDR, a0);
            check("req_held", oIMEM_REQ, 1);
        end
        ack = 1'b1;
        data = instr;
        step(1);
        ack = 1'b0;
    endtask

    initial begin
        // Reset, with a spurious ACK that must be ignored.
        iRST = 1'b1; ack = 1'b1; data = 32'hDEAD_BEEF;
        step(1);
        chk_on = 1'b1;
        step(2);
        check("rst_req", oIMEM_REQ, 0);
        check("rst_pc", oPC, RST_PC);
        check("rst_ir", oIR, 0);
        check("rst_ret", oRETIRED, 0);
        check("rst_trap", oTRAP, 0);
        ack = 1'b0; iRST = 1'b0;
        step(1);
        check("req_after_rst", oIMEM_REQ, 1);

        // addi x0: no write, REQ back 3 cycles after ACK.
        pcbr = 32'h0; taken = 1'b0;
        fetch(32'h0000_0013, 0);
        check("addi_ir", oIR, 32'h0000_0013);
        check("addi_req_c1", oIMEM_REQ, 0);
        step(1);
        check("addi_req_c2", oIMEM_REQ, 0);
        step(1);
        check("addi_we", oRF_WE, 0);
        check("addi_req_c3", oIMEM_REQ, 0);
        step(1);
        check("addi_req_back", oIMEM_REQ, 1);
        check("addi_pc", oPC, 32'h4);
        check("addi_ret", oRETIRED, 1);

        // Jump to 0x100, then jal x1,+8.
        pcbr = 32'h100;
        fetch(32'h0000_006F, 0);
        step(3);
        check("jal0_pc", oPC, 32'h100);
        pcbr = 32'h108;
        fetch(32'h0080_00EF, 0);
        step(2);
        check("jal1_we", oRF_WE, 1);
        step(1);
        check("jal1_we_off", oRF_WE, 0);
        check("jal1_addr", oIMEM_ADDR, 32'h108);
        check("jal1_ret", oRETIRED, 3);

        // Branch at 0x200, not taken then taken.
        pcbr = 32'h200;
        fetch(32'h0000_006F, 0);
        step(3);
        pcbr = 32'h1F0; taken = 1'b0;
        fetch(32'h0000_0063, 0);
        step(2);
        check("br_we", oRF_WE, 0);
        step(1);
        check("br_nt_pc", oPC, 32'h204);
        pcbr = 32'h200;
        fetch(32'h0000_006F, 0);
        step(3);
        check("br_back", oPC, 32'h200);
        pcbr = 32'h1F0; taken = 1'b1;
        fetch(32'h0000_0063, 0);
        step(3);
        check("br_t_pc", oPC, 32'h1F0);
        taken = 1'b0;

        // ACK delayed 5 cycles: address held stable.
        pcbr = 32'h0;
        fetch(32'h0010_0093, 5);
        step(2);
        check("dly_we", oRF_WE, 1);
        step(1);
        check("dly_pc", oPC, 32'h1F4);
        check("dly_ret", oRETIRED, 8);

        // Reset asserted together with ACK.
        check("pre_rst_req", oIMEM_REQ, 1);
        iRST = 1'b1; ack = 1'b1; data = 32'h1234_5093;
        step(1);
        check("rack_ir", oIR, 0);
        check("rack_pc", oPC, RST_PC);
        check("rack_req", oIMEM_REQ, 0);
        iRST = 1'b0; ack = 1'b0;
        step(1);
        check("rack_req_after", oIMEM_REQ, 1);

        // PC wrap from 0xFFFF_FFFC.
        pcbr = 32'hFFFF_FFFC;
        fetch(32'h0000_006F, 0);
        step(3);
        check("wrap_pre", oPC, 32'hFFFF_FFFC);
        pcbr = 32'h0;
        fetch(32'h0000_0013, 0);
        step(3);
        check("wrap_pc", oPC, 32'h0);
        check("wrap_trap", oTRAP, 0);
        check("wrap_ret", oRETIRED, 2);

        // JALR to a misaligned target traps.
        pcbr = 32'h0000_0102;
        fetch(32'h0000_00E7, 0);
        step(2);
        check("jalr_trap", oTRAP, 1);
        check("jalr_we", oRF_WE, 0);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("jalr_req_off", oIMEM_REQ, 0);
            check("jalr_we_off", oRF_WE, 0);
        end
        check("jalr_ret", oRETIRED, 2);
        check("jalr_pc", oPC, 32'h0);

        // Illegal opcode traps after a fresh reset.
        iRST = 1'b1;
        step(2);
        iRST = 1'b0;
        pcbr = 32'h0;
        fetch(32'h0000_007F, 0);
        step(2);
        check("ill_trap", oTRAP, 1);
        step(3);
        check("ill_req", oIMEM_REQ, 0);
        check("ill_ret", oRETIRED, 0);

        // Retired counter increment wraps.
        check("ret_wrap", retired_inc(32'hFFFF_FFFF), 32'h0);
        check("ret_inc", retired_inc(32'h0000_0007), 32'h8);

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
